dlfloat16_reduce: RTL and testbench
===================================

# dlfloat16_reduce

Streaming min/max reduction unit for DLFloat16 vectors. It accepts a stream of DLFloat16 elements (1 sign, 6 exponent, 9 mantissa bits) over a valid/ready handshake and applies the FPU compare ordering to each element. It returns the selected extreme value, its position and the element count as one registered result beat, with the FPU's 5-bit exception vector. It sits between the vector load path and the FPU result writeback, and issues reductions that would otherwise need N-1 back-to-back compare ops.

## Interface
- IDX_W, default 8: index width; MAX_LEN = 2^IDX_W elements per stream.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input element valid.
- in_ready  out  1  unit can accept an element.
- in_data  in  16  DLFloat16 element: [15] sign, [14:9] exponent, [8:0] mantissa.
- in_last  in  1  final element of the current stream.
- op  in  2  2'b01 = min, 2'b10 = max, other values illegal; sampled on the first beat only.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  16  selected element (bit-exact copy of an input).
- out_idx  out  IDX_W  zero-based index of the selected element.
- out_count  out  IDX_W+1  number of elements folded into the result.
- exceptions  out  5  {invalid, inexact, overflow, underflow, div_zero}; valid with out_valid.

## Operation
- Ordering is sign-magnitude, identical to the FPU compare:
  - Differing signs: the negative operand is less, so -0 (16'h8000) < +0 (16'h0000).
  - Equal signs: compare exponent, then mantissa, as unsigned values. The result is inverted when both operands are negative.
  - Equal bit patterns compare equal.
- Replacement rule: a new element replaces the accumulator only when it is strictly less (min) or strictly greater (max). On a tie the earliest index is kept.
- FSM states: IDLE, ACC, DROP, HOLD.
  - IDLE: in_ready=1. The first accepted beat loads acc=in_data, idx=0, count=1 and latches op. Next state is HOLD if in_last=1, else ACC.
  - ACC: in_ready=1. Each accepted beat is compared, count increments, and a running position counter tracks the index.
    - Beat with in_last=1: go to HOLD.
    - Beat that brings count to MAX_LEN without in_last: go to DROP.
  - DROP: in_ready=1. Beats are accepted and discarded and count stays at MAX_LEN. The in_last beat goes to HOLD.
  - HOLD: in_ready=0, out_valid=1, and all out_* and exceptions are held stable. When out_valid and out_ready are both high, go to IDLE.
- Exceptions are sticky per stream and clear on the first beat of the next stream:
  - invalid: op illegal, or any folded element equals 16'h7FFF or 16'hFFFF (the NaN/Inf encodings). Those elements are still compared by bit pattern.
  - overflow: the stream was truncated (a DROP state was entered).
  - inexact, underflow, div_zero: always 0.
- Illegal op: out_data=16'h0000, out_idx=0. count still reflects the beats received.

## Timing
- Reset (synchronous, rst=1 at a clk edge) sets:
  - State IDLE; in_ready=1.
  - out_valid=0, out_data=16'h0000, out_idx=0, out_count=0, exceptions=5'b0.
  - All accumulator, counter and flag state cleared.
- Reset mid-stream or during HOLD discards the partial or pending result with no output beat. in_ready is 1 on the cycle after reset.
- Latency: out_valid rises on the cycle after the in_last beat is accepted. This holds for single-element streams too.
- Throughput: one element per cycle while in IDLE/ACC/DROP.
- There is one mandatory bubble after each result handshake: in_ready=1 again on the cycle after the HOLD-to-IDLE transition.
- in_ready does not depend combinationally on in_valid. out_valid does not depend on out_ready.
- in_valid=1 while in_ready=0 (HOLD) is not a transfer; the data must be held by the source.
- A beat transfers only on a rising edge with in_valid=1 and in_ready=1.
- The index and count counters must not wrap. count saturates at MAX_LEN, and out_idx never exceeds MAX_LEN-1.

## Test plan
- min, stream {0x3E00, 0xBE00, 0x4000, 0xBE00 (last)} -> out_data=0xBE00, out_idx=1, out_count=4, exceptions=0, with out_valid one cycle after the last beat.
- max, stream {0x8000, 0x0000 (last)} -> out_data=0x0000, out_idx=1. Then min on the same stream -> out_data=0x8000, out_idx=0.
- max, single element 0x7FFF with in_last=1 -> out_data=0x7FFF, out_idx=0, out_count=1, exceptions=5'b10000.
- IDX_W=2, max, 6 beats {1,2,3,9,9,9 (last)} in hex encodings -> result is the max of the first 4 (index 3), out_count=4, exceptions=5'b00100, and all 6 beats are accepted.
- Hold out_ready=0 for 5 cycles in HOLD -> outputs stable and in_ready=0 throughout. Release -> result transfers once, then in_ready=1 one cycle later.
- Assert rst for one cycle mid-stream after 3 beats -> no out_valid, all outputs zero. Then a new 2-element op=2'b11 stream -> out_data=0x0000, out_count=2, exceptions=5'b10000.

Source files
------------

// File: rtl/dlfloat16_reduce.sv
// Streaming min/max reduction over DLFloat16 elements using sign-magnitude
// FPU compare ordering; emits the extreme value, its index and the element count.
module dlfloat16_reduce #(
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_last,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic [IDX_W:0]   out_count,
  output logic [4:0]       exceptions
);

  localparam logic [1:0]     OP_MIN  = 2'b01;
  localparam logic [1:0]     OP_MAX  = 2'b10;
  localparam logic [IDX_W:0] MAX_LEN = {1'b1, {IDX_W{1'b0}}};
  localparam logic [IDX_W:0] ONE     = {{IDX_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, ACC, DROP, HOLD} state_t;

  state_t           state_q, state_d;
  logic [15:0]      acc_q, acc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W:0]   count_q, count_d;
  logic [1:0]       op_q, op_d;
  logic             inv_q, inv_d;
  logic             ovf_q, ovf_d;
  logic             fire, nan_in, op_legal, take;

  // Strict a < b in sign-magnitude order; -0 sorts below +0.
  function automatic logic less_than(input logic [15:0] a, input logic [15:0] b);
    if (a[15] != b[15]) return a[15];
    else if (a[15])     return a[14:0] > b[14:0];
    else                return a[14:0] < b[14:0];
  endfunction

  assign in_ready  = (state_q != HOLD);
  assign fire      = in_valid && in_ready;
  assign nan_in    = (in_data[14:0] == 15'h7FFF);
  assign op_legal  = (op == OP_MIN) || (op == OP_MAX);
  assign take      = ((op_q == OP_MIN) && less_than(in_data, acc_q)) ||
                     ((op_q == OP_MAX) && less_than(acc_q, in_data));

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    count_d = count_q;
    op_d    = op_q;
    inv_d   = inv_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: if (fire) begin
        op_d    = op;
        acc_d   = op_legal ? in_data : 16'h0000;
        idx_d   = '0;
        count_d = ONE;
        inv_d   = !op_legal || nan_in;
        ovf_d   = 1'b0;
        state_d = in_last ? HOLD : ACC;
      end
      ACC: if (fire) begin
        // count_q is the position of this beat and is always below MAX_LEN here
        count_d = count_q + ONE;
        inv_d   = inv_q || nan_in;
        if (take) begin
          acc_d = in_data;
          idx_d = count_q[IDX_W-1:0];
        end
        if (in_last) state_d = HOLD;
        else if (count_d == MAX_LEN) begin
          state_d = DROP;
          ovf_d   = 1'b1;
        end
      end
      DROP: if (fire && in_last) state_d = HOLD;
      HOLD: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      idx_q   <= '0;
      count_q <= '0;
      op_q    <= '0;
      inv_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      op_q    <= op_d;
      inv_q   <= inv_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid  = (state_q == HOLD);
  assign out_data   = acc_q;
  assign out_idx    = idx_q;
  assign out_count  = count_q;
  assign exceptions = {inv_q, 1'b0, ovf_q, 2'b00};

endmodule

// File: tb/tb_dlfloat16_reduce.sv
// Drives two lockstep instances (IDX_W=8 and IDX_W=2) with the same streams and
// checks each against a value-ordering reference model.
module tb_dlfloat16_reduce;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_last, out_ready;
  logic [15:0] in_data;
  logic [1:0]  op;

  logic        a_in_ready, a_out_valid;
  logic [15:0] a_out_data;
  logic [7:0]  a_out_idx;
  logic [8:0]  a_out_count;
  logic [4:0]  a_exc;

  logic        b_in_ready, b_out_valid;
  logic [15:0] b_out_data;
  logic [1:0]  b_out_idx;
  logic [2:0]  b_out_count;
  logic [4:0]  b_exc;

  dlfloat16_reduce #(.IDX_W(8)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .in_last(in_last), .op(op), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_data(a_out_data), .out_idx(a_out_idx),
    .out_count(a_out_count), .exceptions(a_exc));

  dlfloat16_reduce #(.IDX_W(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .in_last(in_last), .op(op), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_data(b_out_data), .out_idx(b_out_idx),
    .out_count(b_out_count), .exceptions(b_exc));

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] strm[$];

  // Total order key: negatives map below zero, -0 -> -1, +0 -> 0.
  function automatic int key(input logic [15:0] x);
    return x[15] ? -int'(x[14:0]) - 1 : int'(x[14:0]);
  endfunction

  task automatic model(input logic [1:0] o, input int maxl, output logic [15:0] d,
                       output int idx, output int cnt, output logic [4:0] exc);
    int  n;
    logic legal, inv;
    n     = strm.size();
    cnt   = (n < maxl) ? n : maxl;
    legal = (o == 2'b01) || (o == 2'b10);
    inv   = !legal;
    d     = 16'h0000;
    idx   = 0;
    for (int k = 0; k < cnt; k++) begin
      if (strm[k] == 16'h7FFF || strm[k] == 16'hFFFF) inv = 1'b1;
      if (legal) begin
        if (k == 0) d = strm[k];
        else if ((o == 2'b01) ? (key(strm[k]) < key(d)) : (key(strm[k]) > key(d))) begin
          d   = strm[k];
          idx = k;
        end
      end
    end
    exc = {inv, 1'b0, (n > maxl), 2'b00};
  endtask

  task automatic drive_beat(input logic [15:0] d, input logic last);
    int guard;
    guard = 0;
    @(negedge clk);
    if ($urandom_range(0, 3) == 0) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!a_in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    n_cmp++;
    if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1 || a_out_valid !== 1'b0 || b_out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL beat_accept: ready a=%b b=%b valid a=%b b=%b, required ready=1 valid=0",
               a_in_ready, b_in_ready, a_out_valid, b_out_valid);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Streams strm with operator o, stalls the result hold_cyc cycles, then drains it.
  task automatic run_stream(input string name, input logic [1:0] o, input int hold_cyc);
    logic [15:0] ad, bd;
    int ai, ac, bi, bc;
    logic [4:0] ae, be;
    model(o, 256, ad, ai, ac, ae);
    model(o, 4, bd, bi, bc, be);
    op = o;
    for (int k = 0; k < strm.size(); k++) drive_beat(strm[k], k == strm.size() - 1);
    for (int h = 0; h <= hold_cyc; h++) begin
      @(negedge clk);
      n_cmp++;
      if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0 || a_out_data !== ad ||
          a_out_idx !== 8'(ai) || a_out_count !== 9'(ac) || a_exc !== ae) begin
        n_err++;
        $display("FAIL %s/a cyc%0d: got v=%b r=%b d=%h i=%0d c=%0d e=%b, required v=1 r=0 d=%h i=%0d c=%0d e=%b",
                 name, h, a_out_valid, a_in_ready, a_out_data, a_out_idx, a_out_count, a_exc, ad, ai, ac, ae);
      end
      n_cmp++;
      if (b_out_valid !== 1'b1 || b_in_ready !== 1'b0 || b_out_data !== bd ||
          b_out_idx !== 2'(bi) || b_out_count !== 3'(bc) || b_exc !== be) begin
        n_err++;
        $display("FAIL %s/b cyc%0d: got v=%b r=%b d=%h i=%0d c=%0d e=%b, required v=1 r=0 d=%h i=%0d c=%0d e=%b",
                 name, h, b_out_valid, b_in_ready, b_out_data, b_out_idx, b_out_count, b_exc, bd, bi, bc, be);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0 || a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s/drain: valid a=%b b=%b ready a=%b b=%b, required valid=0 ready=1",
               name, a_out_valid, b_out_valid, a_in_ready, b_in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; op = 2'b01; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_out_data !== 16'h0 || a_out_idx !== 8'h0 ||
        a_out_count !== 9'h0 || a_exc !== 5'h0 || b_in_ready !== 1'b1 || b_out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: r=%b v=%b d=%h i=%0d c=%0d e=%b, required r=1 v=0 d=0 i=0 c=0 e=0",
               a_in_ready, a_out_valid, a_out_data, a_out_idx, a_out_count, a_exc);
    end
  endtask

  task automatic test_directed();
    strm = '{16'h3E00, 16'hBE00, 16'h4000, 16'hBE00};
    run_stream("min_basic", 2'b01, 0);
    strm = '{16'h8000, 16'h0000};
    run_stream("max_zero", 2'b10, 0);
    run_stream("min_zero", 2'b01, 0);
    strm = '{16'h7FFF};
    run_stream("single_nan", 2'b10, 0);
  endtask

  task automatic test_truncate();
    strm = '{16'h3E00, 16'h4000, 16'h4100, 16'h4440, 16'h4440, 16'h4440};
    run_stream("truncate", 2'b10, 0);
    strm = '{16'hC000, 16'hBE00, 16'hC100, 16'hC440};
    run_stream("exact_max_len", 2'b01, 0);
  endtask

  task automatic test_backpressure();
    strm = '{16'h1234, 16'h9234, 16'h0001};
    run_stream("backpressure", 2'b10, 5);
  endtask

  task automatic test_reset_midstream();
    op = 2'b10;
    drive_beat(16'h4000, 1'b0);
    drive_beat(16'h4100, 1'b0);
    drive_beat(16'hFFFF, 1'b0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_out_data !== 16'h0 || a_out_idx !== 8'h0 ||
          a_out_count !== 9'h0 || a_exc !== 5'h0 || b_out_valid !== 1'b0 || b_out_count !== 3'h0) begin
        n_err++;
        $display("FAIL reset_mid cyc%0d: v=%b r=%b d=%h i=%0d c=%0d e=%b, required v=0 r=1 all zero",
                 c, a_out_valid, a_in_ready, a_out_data, a_out_idx, a_out_count, a_exc);
      end
    end
    strm = '{16'h4000, 16'hC000};
    run_stream("illegal_op", 2'b11, 0);
  endtask

  task automatic test_random();
    logic [1:0] o;
    int len;
    for (int s = 0; s < 60; s++) begin
      strm.delete();
      len = $urandom_range(1, 7);
      for (int k = 0; k < len; k++) begin
        case ($urandom_range(0, 7))
          0: strm.push_back(16'h0000);
          1: strm.push_back(16'h8000);
          2: strm.push_back(16'h7FFF);
          3: strm.push_back(16'hFFFF);
          4: strm.push_back(k > 0 ? strm[0] : 16'h3E00);
          default: strm.push_back(16'($urandom));
        endcase
      end
      case ($urandom_range(0, 7))
        0: o = 2'b00;
        1: o = 2'b11;
        2, 3, 4: o = 2'b01;
        default: o = 2'b10;
      endcase
      run_stream("random", o, $urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_truncate();
    test_backpressure();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
